npc_exec_sequencer: RTL and testbench

Multi-cycle control FSM for the NPC core. It sequences one instruction at a time through fetch, decode, execute, optional store and writeback. It forms the 8-bit decode pattern for the micro-command decode table and registers the 7-bit micro command that table returns. From that command it issues the per-phase enables for the PC, register file and data memory, and it stops the core on EBREAK or on an undecodable instruction.

---
 rtl/npc_ctrl_pkg.sv | 30 +++
 rtl/npc_exec_sequencer_if.sv | 24 ++
 rtl/npc_exec_sequencer_fetch_watchdog.sv | 33 +++
 rtl/npc_exec_sequencer.sv | 167 ++++++++++++++++
 tb/tb_npc_exec_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC control path: sequencer state
// encoding, micro-command layout and decode-pattern constants.
package npc_ctrl_pkg;

    localparam int MICRO_LEN   = 7;
    localparam int PATTERN_LEN = 8;

    // {funct3, opcode[6:2]} of EBREAK
    localparam logic [PATTERN_LEN-1:0] EBREAK_PATTERN = 8'b00011100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic       regen;
        logic       pcjen;
        logic       mwen;
        logic       pcren;
        logic [2:0] imm_type;
    } micro_cmd_t;

endpackage

// File: rtl/npc_exec_sequencer_if.sv
// Fetch, decode-table and store handshakes between the sequencer (master)
// and the rest of the core (slave).
interface npc_exec_sequencer_if import npc_ctrl_pkg::*; ();

    logic                   if_req;
    logic                   if_valid;
    logic [31:0]            if_inst;
    logic [PATTERN_LEN-1:0] lut_pattern;
    logic [MICRO_LEN-1:0]   micro_cmd;
    logic                   lut_hit;
    logic                   mem_req;
    logic                   mem_ack;

    modport master (
        output if_req, lut_pattern, mem_req,
        input  if_valid, if_inst, micro_cmd, lut_hit, mem_ack
    );

    modport slave (
        input  if_req, lut_pattern, mem_req,
        output if_valid, if_inst, micro_cmd, lut_hit, mem_ack
    );

endinterface

// File: rtl/npc_exec_sequencer_fetch_watchdog.sv
// Counts consecutive stalled FETCH cycles; expired fires on the stalled
// cycle that brings the count to FETCH_TIMEOUT, so the sequencer leaves
// FETCH on that same edge. Only built with NPC_FETCH_WATCHDOG_EN.
module fetch_watchdog #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

    logic [CW-1:0] cnt_r;

    // stall counter: cleared outside FETCH, saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (tick && (cnt_r != CW'(FETCH_TIMEOUT))) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = tick & (cnt_r == CW'(FETCH_TIMEOUT - 32'd1));

endmodule

// File: rtl/npc_exec_sequencer.sv
// NPC multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Forms the decode-table pattern, registers the returned micro command and
// issues the per-phase strobes. Stops in HALT on EBREAK and in ERR on a
// decode miss. Optional fetch watchdog: define NPC_FETCH_WATCHDOG_EN.
module npc_exec_sequencer import npc_ctrl_pkg::*; #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    npc_exec_sequencer_if.master        bus,
    output logic [2:0]                  imm_type,
    output logic                        pc_sel_jump,
    output logic                        pc_sel_reg,
    output logic                        rf_we,
    output logic                        pc_we,
    output logic                        busy,
    output logic                        halt,
    output logic                        err,
    output logic [CNT_W-1:0]            retire_cnt
);

    seq_state_e             state_r;
    seq_state_e             state_next_s;
    logic [31:0]            inst_r;
    micro_cmd_t             ucmd_r;
    logic [CNT_W-1:0]       retire_cnt_r;
    logic [PATTERN_LEN-1:0] pattern_s;
    logic                   wd_expired_s;
    logic                   if_req_s;
    logic                   mem_req_s;
    logic                   unused_inst_s;

    assign pattern_s     = {inst_r[14:12], inst_r[6:2]};
    assign unused_inst_s = ^{inst_r[31:15], inst_r[11:7], inst_r[1:0]};

`ifdef NPC_FETCH_WATCHDOG_EN
    logic wd_clr_s;
    logic wd_tick_s;

    assign wd_clr_s  = (state_r != ST_FETCH);
    assign wd_tick_s = (state_r == ST_FETCH) & ~bus.if_valid;

    fetch_watchdog #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr_s),
        .tick    (wd_tick_s),
        .expired (wd_expired_s)
    );
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (FETCH_TIMEOUT == 32'd0);
    assign wd_expired_s     = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state decision
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_FETCH;
                else       state_next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.if_valid)      state_next_s = ST_DECODE;
                else if (wd_expired_s) state_next_s = ST_ERR;
                else                   state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (!bus.lut_hit)                     state_next_s = ST_ERR;
                else if (pattern_s == EBREAK_PATTERN) state_next_s = ST_HALT;
                else                                  state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (ucmd_r.mwen) state_next_s = ST_MEM;
                else             state_next_s = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ack) state_next_s = ST_WB;
                else             state_next_s = ST_MEM;
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_HALT: state_next_s = ST_HALT;
            ST_ERR:  state_next_s = ST_ERR;
            default: state_next_s = ST_ERR;
        endcase
    end

    // per-state strobes and status decoded from the state register
    always_comb begin
        if_req_s  = 1'b0;
        mem_req_s = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b0;
        halt      = 1'b0;
        err       = 1'b0;
        case (state_r)
            ST_IDLE:   busy = 1'b0;
            ST_FETCH:  begin if_req_s = 1'b1; busy = 1'b1; end
            ST_DECODE: busy = 1'b1;
            ST_EXEC:   busy = 1'b1;
            ST_MEM:    begin mem_req_s = 1'b1; busy = 1'b1; end
            ST_WB:     begin pc_we = 1'b1; rf_we = ucmd_r.regen; busy = 1'b1; end
            ST_HALT:   halt = 1'b1;
            ST_ERR:    err = 1'b1;
            default:   err = 1'b1;
        endcase
    end

    assign bus.if_req      = if_req_s;
    assign bus.mem_req     = mem_req_s;
    assign bus.lut_pattern = pattern_s;

    // instruction register, loaded only on an accepted fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= 32'd0;
        end else if ((state_r == ST_FETCH) && bus.if_valid) begin
            inst_r <= bus.if_inst;
        end else begin
            inst_r <= inst_r;
        end
    end

    // micro command captured in DECODE and held until the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucmd_r <= '0;
        end else if (state_r == ST_DECODE) begin
            ucmd_r <= micro_cmd_t'(bus.micro_cmd);
        end else begin
            ucmd_r <= ucmd_r;
        end
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= '0;
        end else if (state_r == ST_WB) begin
            retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign imm_type    = ucmd_r.imm_type;
    assign pc_sel_jump = ucmd_r.pcjen;
    assign pc_sel_reg  = ucmd_r.pcren;
    assign retire_cnt  = retire_cnt_r;

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Directed bench for npc_exec_sequencer: table of non-store instructions
// plus hand-written store, EBREAK, decode-miss, reset and fetch-stall runs.
module tb_npc_exec_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       imm_type;
    logic             pc_sel_jump;
    logic             pc_sel_reg;
    logic             rf_we;
    logic             pc_we;
    logic             busy;
    logic             halt;
    logic             err;
    logic [CNT_W-1:0] retire_cnt;

    npc_exec_sequencer_if bus();

    npc_exec_sequencer #(
        .CNT_W         (CNT_W),
        .FETCH_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .imm_type    (imm_type),
        .pc_sel_jump (pc_sel_jump),
        .pc_sel_reg  (pc_sel_reg),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .busy        (busy),
        .halt        (halt),
        .err         (err),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  mc;
        logic [7:0]  pat;
        logic        exp_rf_we;
        logic [2:0]  exp_imm;
        logic        exp_jmp;
        logic        exp_preg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_req"},   {31'd0, bus.if_req},      32'd0);
        chk({tag, "_mem_req"},  {31'd0, bus.mem_req},     32'd0);
        chk({tag, "_pattern"},  {24'd0, bus.lut_pattern}, 32'd0);
        chk({tag, "_imm"},      {29'd0, imm_type},        32'd0);
        chk({tag, "_jmp_reg"},  {30'd0, pc_sel_jump, pc_sel_reg}, 32'd0);
        chk({tag, "_we"},       {30'd0, rf_we, pc_we},    32'd0);
        chk({tag, "_status"},   {29'd0, busy, halt, err}, 32'd0);
        chk({tag, "_retire"},   retire_cnt,               32'd0);
    endtask

    initial begin
        vec_t vt [5];
        int   exp_ret;
        int   mreq_cnt;
        int   pcw_cnt;
        int   pcw_cyc;
        int   rfw_cnt;

        //          inst          mc {rg,pj,mw,pr,imm}  pat    rf    imm     jmp   preg
        vt[0] = '{32'h00100093, 7'b1000001, 8'h04, 1'b1, 3'b001, 1'b0, 1'b0}; // ADDI
        vt[1] = '{32'h008000EF, 7'b1100100, 8'h1B, 1'b1, 3'b100, 1'b1, 1'b0}; // JAL
        vt[2] = '{32'h000080E7, 7'b1001001, 8'h19, 1'b1, 3'b001, 1'b0, 1'b1}; // JALR
        vt[3] = '{32'h00208463, 7'b0100011, 8'h18, 1'b0, 3'b011, 1'b1, 1'b0}; // BEQ
        vt[4] = '{32'h123450B7, 7'b1000101, 8'hAD, 1'b1, 3'b101, 1'b0, 1'b0}; // LUI

        rst_n = 1'b0; start = 1'b0;
        bus.if_valid = 1'b0; bus.if_inst = 32'd0; bus.micro_cmd = 7'd0;
        bus.lut_hit = 1'b0; bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_if_req", {31'd0, bus.if_req}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // ---------------- table-driven non-store instructions ----------------
        exp_ret = 0;
        for (int i = 0; i < 5; i++) begin
            chk("v_fetch_if_req", {31'd0, bus.if_req}, 32'd1);
            bus.if_valid = 1'b1; bus.if_inst = vt[i].inst;
            bus.micro_cmd = vt[i].mc; bus.lut_hit = 1'b1;
            @(negedge clk); // DECODE
            bus.if_valid = 1'b0; bus.if_inst = 32'hFFFFFFFF;
            chk("v_pattern", {24'd0, bus.lut_pattern}, {24'd0, vt[i].pat});
            chk("v_if_req_drop", {31'd0, bus.if_req}, 32'd0);
            start = 1'b1;
            @(negedge clk); // EXEC: stray fetch data and micro command
            bus.if_valid = 1'b1; bus.micro_cmd = 7'h7F;
            chk("v_exec_pc_we", {31'd0, pc_we}, 32'd0);
            @(negedge clk); // WB
            bus.if_valid = 1'b0; start = 1'b0;
            chk("v_wb_pc_we", {31'd0, pc_we}, 32'd1);
            chk("v_wb_rf_we", {31'd0, rf_we}, {31'd0, vt[i].exp_rf_we});
            chk("v_imm", {29'd0, imm_type}, {29'd0, vt[i].exp_imm});
            chk("v_sel", {30'd0, pc_sel_jump, pc_sel_reg}, {30'd0, vt[i].exp_jmp, vt[i].exp_preg});
            chk("v_pattern_hold", {24'd0, bus.lut_pattern}, {24'd0, vt[i].pat});
            exp_ret++;
            @(negedge clk); // FETCH
            chk("v_retire", retire_cnt, exp_ret);
            chk("v_fetch_pc_we", {31'd0, pc_we}, 32'd0);
        end

        // ---------------- SW with mem_ack three cycles into MEM ----------------
        mreq_cnt = 0; pcw_cnt = 0; pcw_cyc = 0; rfw_cnt = 0;
        chk("sw_if_req", {31'd0, bus.if_req}, 32'd1);
        bus.if_valid = 1'b1; bus.if_inst = 32'h00112023;
        bus.micro_cmd = 7'b0010010; bus.lut_hit = 1'b1;
        @(negedge clk);
        bus.if_valid = 1'b0;
        chk("sw_pattern", {24'd0, bus.lut_pattern}, 32'h48);
        for (int c = 2; c <= 8; c++) begin
            if (bus.mem_req) mreq_cnt++;
            if (pc_we) begin pcw_cnt++; pcw_cyc = c; end
            if (rf_we) rfw_cnt++;
            bus.mem_ack = bus.mem_req && (mreq_cnt == 3);
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        chk("sw_mem_req_cycles", mreq_cnt, 32'd3);
        chk("sw_pc_we_pulses", pcw_cnt, 32'd1);
        chk("sw_latency", pcw_cyc, 32'd7);
        chk("sw_rf_we", rfw_cnt, 32'd0);
        exp_ret++;
        chk("sw_retire", retire_cnt, exp_ret);
        chk("sw_refetch", {31'd0, bus.if_req}, 32'd1);

        // ---------------- EBREAK ----------------
        bus.if_valid = 1'b1; bus.if_inst = 32'h00100073;
        bus.micro_cmd = 7'b0000000; bus.lut_hit = 1'b1;
        @(negedge clk);
        bus.if_valid = 1'b0;
        chk("eb_pattern", {24'd0, bus.lut_pattern}, 32'h1C);
        @(negedge clk);
        chk("eb_halt", {31'd0, halt}, 32'd1);
        chk("eb_busy", {31'd0, busy}, 32'd0);
        pcw_cnt = 0;
        start = 1'b1; bus.if_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (pc_we || bus.if_req) pcw_cnt++;
            @(negedge clk);
        end
        start = 1'b0; bus.if_valid = 1'b0;
        chk("eb_no_activity", pcw_cnt, 32'd0);
        chk("eb_sticky", {29'd0, busy, halt, err}, 32'b010);
        chk("eb_retire", retire_cnt, exp_ret);

        // ---------------- decode miss ----------------
        rst_n = 1'b0; #1;
        chk_zero("rst_halt");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bus.if_valid = 1'b1; bus.if_inst = 32'h00100093;
        bus.micro_cmd = 7'b1000001; bus.lut_hit = 1'b0;
        @(negedge clk);
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("miss_err", {29'd0, busy, halt, err}, 32'b001);
        pcw_cnt = 0;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (pc_we || bus.if_req) pcw_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("miss_quiet", pcw_cnt, 32'd0);
        chk("miss_err_sticky", {31'd0, err}, 32'd1);
        chk("miss_retire", retire_cnt, 32'd0);

        // ---------------- reset during MEM ----------------
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bus.if_valid = 1'b1; bus.if_inst = 32'h00112023;
        bus.micro_cmd = 7'b0010010; bus.lut_hit = 1'b1;
        @(negedge clk); bus.if_valid = 1'b0;   // DECODE
        @(negedge clk);                        // EXEC
        @(negedge clk);                        // MEM
        chk("rm_mem_req", {31'd0, bus.mem_req}, 32'd1);
        #2; rst_n = 1'b0; #1;
        chk_zero("rm_reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rm_idle", {31'd0, bus.if_req}, 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("rm_refetch", {31'd0, bus.if_req}, 32'd1);
        bus.if_valid = 1'b1;
        @(negedge clk); bus.if_valid = 1'b0;   // DECODE
        @(negedge clk);                        // EXEC
        @(negedge clk);                        // MEM
        chk("rm_mem_req2", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        @(negedge clk); bus.mem_ack = 1'b0;    // WB
        chk("rm_wb_pc_we", {30'd0, pc_we, rf_we}, 32'b10);
        @(negedge clk);
        chk("rm_retire", retire_cnt, 32'd1);

        // ---------------- fetch with no if_valid ----------------
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;          // FETCH cycle 1
`ifdef NPC_FETCH_WATCHDOG_EN
        repeat (3) @(negedge clk);             // FETCH cycle 4
        chk("wd_not_yet", {30'd0, bus.if_req, err}, 32'b10);
        @(negedge clk);
        chk("wd_err", {30'd0, bus.if_req, err}, 32'b01);
`else
        repeat (100) @(negedge clk);
        chk("stall_if_req", {29'd0, bus.if_req, busy, err}, 32'b110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
